// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic inter-stage pipeline register with a
// valid/ready handshake, a 2-entry skid buffer, synchronous flush and
// forced-NOP control on bubbles.
// Optional build macro PIPE_STAGE_STATS_EN adds the stall_cnt and
// bubble_cnt occupancy counters.
module pipe_stage_elastic #(
  parameter int unsigned    DP_W   = 133,
  parameter int unsigned    CR_W   = 5,
  parameter logic [CR_W-1:0] CR_NOP = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DP_W-1:0] in_dp,
  input  logic [CR_W-1:0] in_cr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DP_W-1:0] out_dp,
  output logic [CR_W-1:0] out_cr
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DP_W-1:0] main_dp, skid_dp;
  logic [CR_W-1:0] main_cr, skid_cr;
  logic            main_v;
  logic            in_fire, out_fire;
  logic            ld_main_in, ld_main_skid, ld_skid;

  // Valid bits are decoded from the registered state, so in_ready has
  // no combinational dependence on out_ready.
  assign main_v    = (state != EMPTY);
  assign in_ready  = (state != TWO);
  assign out_valid = main_v;
  assign out_dp    = main_dp;
  assign out_cr    = main_v ? main_cr : CR_NOP;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready;

  // State register; reset drops every in-flight entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Next-state and entry-load decisions; flush overrides any accept.
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = TWO;
            ld_skid   = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt    = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Main entry payload; holds its last value while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_dp <= '0;
      main_cr <= CR_NOP;
    end else if (ld_main_in) begin
      main_dp <= in_dp;
      main_cr <= in_cr;
    end else if (ld_main_skid) begin
      main_dp <= skid_dp;
      main_cr <= skid_cr;
    end
  end

  // Skid entry payload, captured only when main is blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_dp <= '0;
      skid_cr <= CR_NOP;
    end else if (ld_skid) begin
      skid_dp <= in_dp;
      skid_cr <= in_cr;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Saturating stall/bubble counters; flush does not touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (!main_v && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic inter-stage pipeline register. It is the generalised successor to the fixed-width EX/MEM register pair, and any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it.
- Datapath and controller fields are split, as in the existing stage registers.
- Adds a valid/ready handshake, a 2-entry skid buffer so full throughput survives back-pressure, synchronous flush, and forced-NOP control on bubbles.

Parameters:
- DP_W, 133, datapath field width (alu_result, write_data, pc_plus4, ext_imm = 4x32, plus rd = 5).
- CR_W, 5, controller field width (reg_write, result_src[1:0], mem_write, lui).
- CR_NOP, {CR_W{1'b0}}, control value driven while out_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries (branch taken / hazard).
- in_valid  in  1  upstream stage has a valid instruction.
- in_ready  out  1  block can accept this cycle.
- in_dp  in  DP_W  upstream datapath fields.
- in_cr  in  CR_W  upstream control fields.
- out_valid  out  1  downstream output holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_dp  out  DP_W  registered datapath fields.
- out_cr  out  CR_W  registered control fields; CR_NOP when out_valid=0.

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry, each with data, control and a valid bit.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- in_ready = (state != TWO). It is registered (derived from skid valid only) and never combinationally depends on out_ready.
- out_valid = main valid. out_dp and out_cr come straight from main-entry flops.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main <= input.
  - ONE: in_fire & out_fire -> ONE, main <= input.
  - ONE: in_fire & !out_ready -> TWO, skid <= input.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: otherwise hold.
  - TWO: out_fire -> ONE, main <= skid. Otherwise hold. in_fire is impossible in TWO.
- Latency: input accepted at edge N appears on out_* after edge N, when the stage is EMPTY or when ONE with out_fire.
- Throughput: 1 per cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is never bypassed.
- Held data remains stable while out_valid=1 and out_ready=0.
- Bubble: out_cr = CR_NOP whenever out_valid=0, so no reg_write or mem_write can leak.
- out_dp while invalid: holds its last value (don't-care, but deterministic).
- Flush: at the next edge, main and skid valid <= 0, state -> EMPTY.
  - An in_fire in the same cycle is discarded; flush has priority.
  - An out_fire in the same cycle still counts as consumed downstream.
- Reset (rst=0, asynchronous):
  - state EMPTY, out_valid=0, in_ready=1, out_cr=CR_NOP, out_dp=0.
  - All in-flight entries are dropped immediately, including mid-transfer or in TWO.
  - Release is synchronised by the surrounding design.
- Width rules: no arithmetic on payload; fields pass bit-exact.
- No combinational path from in_* to out_*.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with out_valid=0.
  - Both are zeroed by rst, saturate at 32'hFFFF_FFFF and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-TWO: fill both entries (in_dp 1, 2, out_ready=0), assert rst=0 between edges -> out_valid=0, in_ready=1, out_cr=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, in_valid=1 with in_dp 0x10..0x1F over 16 cycles -> out_dp 0x10..0x1F on consecutive cycles, each one cycle after input, in_ready constantly 1.
- Back-pressure: send A=0xAA, B=0xBB with out_ready=0 -> after B, in_ready=0 and out_dp=0xAA held stable; raise out_ready -> 0xAA then 0xBB, in_ready returns to 1 one cycle after the first pop.
- Flush priority: in TWO, flush=1 with in_valid=1, in_dp=0xCC -> next cycle out_valid=0, out_cr=0, and 0xCC never appears on out_dp.
- Bubble NOP: in_cr=5'b11111 accepted, then in_valid=0 -> after consumption out_valid=0 and out_cr=5'b00000 while out_dp still shows the last payload.
- Stats (PIPE_STAGE_STATS_EN): 3 cycles of out_valid=1, out_ready=0, then 2 empty cycles -> stall_cnt=3, bubble_cnt≥2; flush leaves both unchanged.
